// File: rtl/eq_sched_pkg.sv
// Shared types and sizing helpers for the slice-serial equality scheduler.
package eq_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESP    = 2'd2
  } state_e;

  // Number of SLICE-bit chunks in a WIDTH-bit operand.
  function automatic int calc_nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // Requester id width (at least one bit).
  function automatic int calc_idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  // Width of the slices-examined count, which must hold 1..NSLICE.
  function automatic int calc_cw(input int nslice);
    return $clog2(nslice + 1);
  endfunction

  // Width of the slice index register, which holds 0..NSLICE-1.
  function automatic int calc_sw(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/eq_slice.sv
// SLICE-bit combinational equality: per-bit XNOR, then AND-reduce.
module eq_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic             eq
);

  logic [SLICE-1:0] bit_eq;

  // Each bit matches when a and b agree; the slice matches when all bits do.
  always_comb begin
    bit_eq = ~(a ^ b);
    eq     = &bit_eq;
  end

endmodule

// File: rtl/eq_compare_scheduler.sv
// Round-robin scheduler that shares one SLICE-bit equality slice among NREQ
// requesters. The granted operand pair is compared LSB slice first with
// early exit on the first mismatching slice; the result is returned on a
// single response port tagged with the requester id.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is only raised in IDLE and is one-hot. resp_valid is
// high for the whole RESP state, and resp_eq/resp_id/resp_slices stay stable
// until the cycle in which resp_ready is seen high.
module eq_compare_scheduler
  import eq_sched_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int WIDTH  = 32,
  parameter  int SLICE  = 8,
  localparam int NSLICE = calc_nslice(WIDTH, SLICE),
  localparam int IDW    = calc_idw(NREQ),
  localparam int CW     = calc_cw(NSLICE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_eq,
  output logic [IDW-1:0]        resp_id,
  output logic [CW-1:0]         resp_slices,
  output logic                  busy
);

  localparam int SW = calc_sw(NSLICE);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [SW-1:0]      slice_idx_q, slice_idx_d;
  logic [IDW-1:0]     last_grant_q, last_grant_d;
  logic               resp_eq_q, resp_eq_d;
  logic [CW-1:0]      resp_slices_q, resp_slices_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [NREQ-1:0]    grant_oh;

  logic [SLICE-1:0]   a_slices [NSLICE];
  logic [SLICE-1:0]   b_slices [NSLICE];
  logic [SLICE-1:0]   a_sl;
  logic [SLICE-1:0]   b_sl;
  logic               slice_eq;

  // Split the captured operands into slices so the active one is a plain
  // array select on slice_idx_q.
  for (genvar s = 0; s < NSLICE; s++) begin : g_split
    assign a_slices[s] = a_q[s*SLICE +: SLICE];
    assign b_slices[s] = b_q[s*SLICE +: SLICE];
  end

  // Route the active slice of the captured pair into the shared comparator.
  always_comb begin
    a_sl = a_slices[slice_idx_q];
    b_sl = b_slices[slice_idx_q];
  end

  eq_slice #(
    .SLICE (SLICE)
  ) u_eq_slice (
    .a  (a_sl),
    .b  (b_sl),
    .eq (slice_eq)
  );

  // Round-robin pick: first valid requester after last_grant, with wrap.
  always_comb begin
    logic [IDW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_oh    = '0;
    cand        = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IDW'((int'(last_grant_q) + off) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_found) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Next-state logic: accept in IDLE, walk slices in COMPARE, hold in RESP.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    id_d          = id_q;
    slice_idx_d   = slice_idx_q;
    last_grant_d  = last_grant_q;
    resp_eq_d     = resp_eq_q;
    resp_slices_d = resp_slices_q;
    req_ready     = '0;
    case (state_q)
      IDLE: begin
        req_ready = grant_oh;
        if (grant_found) begin
          a_d          = req_a[grant_idx*WIDTH +: WIDTH];
          b_d          = req_b[grant_idx*WIDTH +: WIDTH];
          id_d         = grant_idx;
          slice_idx_d  = '0;
          last_grant_d = grant_idx;
          state_d      = COMPARE;
        end
      end
      COMPARE: begin
        if (!slice_eq) begin
          resp_eq_d     = 1'b0;
          resp_slices_d = CW'(slice_idx_q) + CW'(1);
          state_d       = RESP;
        end else if (slice_idx_q == SW'(NSLICE - 1)) begin
          resp_eq_d     = 1'b1;
          resp_slices_d = CW'(NSLICE);
          state_d       = RESP;
        end else begin
          slice_idx_d = slice_idx_q + SW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= '0;
      slice_idx_q   <= '0;
      last_grant_q  <= IDW'(NREQ - 1);
      resp_eq_q     <= 1'b0;
      resp_slices_q <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      id_q          <= id_d;
      slice_idx_q   <= slice_idx_d;
      last_grant_q  <= last_grant_d;
      resp_eq_q     <= resp_eq_d;
      resp_slices_q <= resp_slices_d;
    end
  end

  // Response port and status are straight decodes of the registers.
  always_comb begin
    resp_valid  = (state_q == RESP);
    busy        = (state_q != IDLE);
    resp_eq     = resp_eq_q;
    resp_id     = id_q;
    resp_slices = resp_slices_q;
  end

endmodule

// File: tb/tb_eq_compare_scheduler.sv
// Self-checking bench for eq_compare_scheduler: reset checks, a vector table,
// hand-written multi-cycle sequences and a randomized run against a
// behavioural model.
module tb_eq_compare_scheduler;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 32;
  localparam int SLICE  = 8;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDW    = 2;
  localparam int CW     = 3;
  localparam int W      = IDW + 1 + CW;

  // ---------------- clock / reset / DUT ----------------
  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_eq;
  logic [IDW-1:0]        resp_id;
  logic [CW-1:0]         resp_slices;
  logic                  busy;

  always #5 clk = ~clk;

  eq_compare_scheduler #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_eq     (resp_eq),
    .resp_id     (resp_id),
    .resp_slices (resp_slices),
    .busy        (busy)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        eq;
    int          sl;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] pack(input int id, input logic eq, input int sl);
    return {IDW'(id), eq, CW'(sl)};
  endfunction

  // Result of an equality check done slice by slice from the LSB end.
  function automatic logic [W-1:0] model_resp(input int id, input logic [31:0] a,
                                              input logic [31:0] b);
    logic [31:0] diff;
    int first_bad;
    diff = a ^ b;
    first_bad = -1;
    for (int s = NSLICE - 1; s >= 0; s--) begin
      if (((diff >> (s * SLICE)) & 32'h0000_00FF) != 0) first_bad = s;
    end
    if (first_bad < 0) return pack(id, 1'b1, NSLICE);
    return pack(id, 1'b0, first_bad + 1);
  endfunction

  // Next owner under round-robin: closest valid requester after 'last'.
  function automatic int model_rr(input int last, input logic [NREQ-1:0] v);
    for (int off = 1; off <= NREQ; off++) begin
      if (v[(last + off) % NREQ]) return (last + off) % NREQ;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
    req_valid[id]               = 1'b1;
    req_a[id*WIDTH +: WIDTH]    = a;
    req_b[id*WIDTH +: WIDTH]    = b;
  endtask

  task automatic drop_req(input int id);
    req_valid[id]            = 1'b0;
    req_a[id*WIDTH +: WIDTH] = $urandom;
    req_b[id*WIDTH +: WIDTH] = $urandom;
  endtask

  // Called at the first negedge after the accept edge; waits for the
  // response, checks its latency (edges after accept) and contents.
  task automatic wait_resp(input logic [W-1:0] exp, input string nm, input int exp_lat);
    int lat;
    lat = 0;
    #1;
    chk({nm, "_busy"}, busy, 1);
    chk({nm, "_ready_in_compare"}, req_ready, 0);
    while (!resp_valid && lat < 40) begin
      @(negedge clk); #1;
      lat++;
    end
    chk({nm, "_latency"}, lat, exp_lat);
    chk({nm, "_resp"}, {resp_id, resp_eq, resp_slices}, exp);
  endtask

  // Single isolated transaction from one requester with resp_ready high.
  task automatic run_vec(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    set_req(v.id, v.a, v.b);
    #1;
    n = 0;
    while (req_ready == 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk({nm, "_grant"}, req_ready, 64'(1) << v.id);
    @(posedge clk);
    @(negedge clk);
    drop_req(v.id);
    wait_resp(pack(v.id, v.eq, v.sl), nm, v.sl);
    @(negedge clk); #1;
    chk({nm, "_resp_dropped"}, resp_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] got;
    logic [W-1:0] held;
    int exp_order[6];
    int g;
    int cyc;
    int last_g;
    int win;
    bit idle_model;
    logic [NREQ-1:0] pend;
    logic [31:0] pa[NREQ];
    logic [31:0] pb[NREQ];
    logic [NREQ-1:0] exp_ready;

    vecs[0] = '{id: 0, a: 32'hDEADBEEF, b: 32'hDEADBEEF, eq: 1'b1, sl: 4};
    vecs[1] = '{id: 1, a: 32'h00000001, b: 32'h00000000, eq: 1'b0, sl: 1};
    vecs[2] = '{id: 1, a: 32'h80000000, b: 32'h00000000, eq: 1'b0, sl: 4};
    vecs[3] = '{id: 3, a: 32'h0000FF00, b: 32'h00000000, eq: 1'b0, sl: 2};
    vecs[4] = '{id: 2, a: 32'h12345678, b: 32'h12005678, eq: 1'b0, sl: 3};

    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // Reset state, during and after reset.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_outputs", {resp_valid, busy, req_ready, resp_eq, resp_id, resp_slices}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_outputs", {resp_valid, busy, req_ready, resp_eq, resp_id, resp_slices}, 0);

    // First lone request from requester 2 is granted at once.
    @(negedge clk);
    set_req(2, 32'h00C0FFEE, 32'h00C0FFEE);
    #1;
    chk("first_grant_req2", req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    drop_req(2);
    wait_resp(pack(2, 1'b1, 4), "first_req2", 4);
    @(negedge clk);

    // Vector table.
    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // All requesters continuously valid: grants rotate 0,1,2,3,0,1.
    // last grant is currently 2 (vecs[4]), so rotation starts at 3; re-reset
    // so that requester 0 has first priority.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_order = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h1111_0000 * (i + 1), 32'h1111_0000 * (i + 1));
    g = 0;
    cyc = 0;
    while (g < 6 && cyc < 300) begin
      #1;
      if (busy) chk("rot_no_ready_busy", req_ready, 0);
      if (resp_valid && exp_q.size() != 0) begin
        got = exp_q.pop_front();
        chk("rot_resp", {resp_id, resp_eq, resp_slices}, got);
      end
      if (req_ready != 0) begin
        chk($sformatf("rot_grant%0d", g), req_ready, 64'(1) << exp_order[g]);
        exp_q.push_back(pack(exp_order[g], 1'b1, 4));
        g++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rot_grant_count", g, 6);
    req_valid = '0;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      #1;
      if (resp_valid) begin
        got = exp_q.pop_front();
        chk("rot_resp", {resp_id, resp_eq, resp_slices}, got);
      end
      @(negedge clk);
      cyc++;
    end
    chk("rot_drained", exp_q.size(), 0);

    // Back-pressure: response held while resp_ready is low, req 3 pending.
    // Last grant is 1, so a lone req 0 is still granted.
    resp_ready = 1'b0;
    set_req(0, 32'hA5A5_1234, 32'hA5A5_1234);
    #1;
    chk("stall_grant0", req_ready, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    drop_req(0);
    set_req(3, 32'h0000_0001, 32'h0000_0002);
    wait_resp(pack(0, 1'b1, 4), "stall_req0", 4);
    held = {resp_id, resp_eq, resp_slices};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk($sformatf("stall_valid%0d", i), resp_valid, 1);
      chk($sformatf("stall_hold%0d", i), {resp_id, resp_eq, resp_slices}, held);
      chk($sformatf("stall_no_ready%0d", i), req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    chk("stall_after_hs_valid", resp_valid, 0);
    chk("stall_grant3", req_ready, 4'b1000);
    @(posedge clk);
    @(negedge clk);
    drop_req(3);
    wait_resp(pack(3, 1'b0, 1), "stall_req3", 1);
    @(negedge clk);

    // Reset during the second compare cycle of a req 2 transaction.
    set_req(2, 32'hCAFE_F00D, 32'hCAFE_F00D);
    #1;
    chk("rstmid_grant2", req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    set_req(0, 32'h0000_0007, 32'h0000_0007);
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_resp_valid", resp_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_grant0_first", req_ready, 4'b0001);
    @(posedge clk);
    @(negedge clk);
    drop_req(0);
    wait_resp(pack(0, 1'b1, 4), "rstmid_req0", 4);
    @(negedge clk); #1;
    chk("rstmid_grant2_next", req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    drop_req(2);
    wait_resp(pack(2, 1'b1, 4), "rstmid_req2", 4);
    @(negedge clk);

    // Randomized traffic against the model, starting from a fresh reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_g = NREQ - 1;
    pend   = '0;
    exp_q.delete();
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0;
      pb[i] = '0;
    end
    cyc = 0;
    while (cyc < 3000) begin
      if (cyc >= 400 && pend == 0 && exp_q.size() == 0) break;
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && cyc < 400 && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          pa[i] = $urandom;
          pb[i] = ($urandom_range(0, 2) == 0) ? pa[i]
                                              : pa[i] ^ (32'(1) << $urandom_range(0, 31));
        end
        if (pend[i]) set_req(i, pa[i], pb[i]);
        else drop_req(i);
      end
      resp_ready = ($urandom_range(0, 2) != 0);
      #1;
      idle_model = (exp_q.size() == 0);
      win = model_rr(last_g, pend);
      exp_ready = (idle_model && win >= 0) ? NREQ'(1) << win : '0;
      chk("rnd_req_ready", req_ready, exp_ready);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("rnd_spurious_resp", resp_valid, 0);
        end else if (resp_ready) begin
          got = exp_q.pop_front();
          chk("rnd_resp", {resp_id, resp_eq, resp_slices}, got);
        end
      end
      if (idle_model && win >= 0) begin
        exp_q.push_back(model_resp(win, pa[win], pb[win]));
        last_g = win;
        pend[win] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    chk("rnd_drained", {pend, 32'(exp_q.size())}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
